// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state encoding, op codes and default width for the mult/div sequencer.
package mult_div_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV = 1'b1;
    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step on unsigned magnitudes.
module div_restore_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    assign trial = {rem_i, bit_i};
    assign diff = trial - {1'b0, dvs_i};
    assign q_o = ~diff[WIDTH];
    assign rem_o = q_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
endmodule

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multi-cycle signed Booth multiply / restoring divide sequencer feeding HI/LO.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hilo_write,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*WIDTH:0] prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic op_q, op_d, qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;
    logic [WIDTH:0] acc_ext, mc_ext, booth_sum;
    logic [2*WIDTH:0] booth_next;
    logic [WIDTH-1:0] step_rem;
    logic step_q, last;
    // Sign-extended accumulator keeps -2^(W-1) * -2^(W-1) from overflowing before the shift.
    assign acc_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    assign mc_ext = {mcand_q[WIDTH-1], mcand_q};
    assign booth_sum = (prod_q[1:0] == 2'b01) ? acc_ext + mc_ext :
                       (prod_q[1:0] == 2'b10) ? acc_ext - mc_ext : acc_ext;
    assign booth_next = {booth_sum, prod_q[WIDTH:1]};
    assign last = (cnt_q == CNT_W'(WIDTH - 1));
    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i(rem_q),
        .bit_i(quo_q[WIDTH-1]),
        .dvs_i(dvs_q),
        .rem_o(step_rem),
        .q_o  (step_q)
    );
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        prod_d = prod_q;
        mcand_d = mcand_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        hi_d = hi_q;
        lo_d = lo_q;
        op_d = op_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        div0_d = div0_q;
        case (state_q)
            IDLE: if (start) begin
                op_d = op;
                cnt_d = '0;
                div0_d = 1'b0;
                if (op == OP_MULT) begin
                    mcand_d = a;
                    prod_d = {{WIDTH{1'b0}}, b, 1'b0};
                    state_d = MULT;
                end else if (b == '0) begin
                    div0_d = 1'b1;
                    state_d = DONE;
                end else begin
                    quo_d = a[WIDTH-1] ? -a : a;
                    dvs_d = b[WIDTH-1] ? -b : b;
                    rem_d = '0;
                    qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
                    rneg_d = a[WIDTH-1];
                    state_d = DIV;
                end
            end
            MULT: begin
                prod_d = booth_next;
                cnt_d = cnt_q + 1'b1;
                state_d = last ? FIX : MULT;
            end
            DIV: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                state_d = last ? FIX : DIV;
            end
            FIX: begin
                hi_d = (op_q == OP_DIV) ? (rneg_q ? -rem_q : rem_q) : prod_q[2*WIDTH:WIDTH+1];
                lo_d = (op_q == OP_DIV) ? (qneg_q ? -quo_q : quo_q) : prod_q[WIDTH:1];
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            prod_q <= '0;
            mcand_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            op_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            div0_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            prod_q <= prod_d;
            mcand_q <= mcand_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            op_q <= op_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            div0_q <= div0_d;
        end
    end
    assign busy = (state_q == MULT) || (state_q == DIV) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign hilo_write = done && !div0_q;
    assign div0 = done && div0_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule
